// File: rtl/writeback_regfile.sv
// Writeback stage: result select, 32x32 integer register file with two combinational read ports, retire counter.
// Optional WB_BYPASS_EN: same-cycle write-through from result_w to the read ports.
module writeback_regfile_rdport #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic [NREGS-1:0][XLEN-1:0] regs_i,
  input  logic [4:0]                 rs_i,
  input  logic                       we_i,
  input  logic [4:0]                 rd_w_i,
  input  logic [XLEN-1:0]            result_i,
  output logic [XLEN-1:0]            data_o
);
  localparam int IDX_W = $clog2(NREGS);

  logic in_range;
  assign in_range = (int'(rs_i) < NREGS);

  always_comb begin
    data_o = '0;
    if (rs_i != 5'd0 && in_range) data_o = regs_i[rs_i[IDX_W-1:0]];
`ifdef WB_BYPASS_EN
    // we_i already excludes x0 and out-of-range targets
    if (we_i && rs_i == rd_w_i) data_o = result_i;
`endif
  end

`ifndef WB_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{we_i, rd_w_i, result_i};
`endif
endmodule

module writeback_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_w,
  input  logic             reg_write_w,
  input  logic [1:0]       result_src_w,
  input  logic [XLEN-1:0]  alu_result_w,
  input  logic [XLEN-1:0]  read_data_w,
  input  logic [XLEN-1:0]  pc_plus4_w,
  input  logic [XLEN-1:0]  imm_ext_w,
  input  logic [4:0]       rd_w,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  output logic [XLEN-1:0]  rd1_d,
  output logic [XLEN-1:0]  rd2_d,
  output logic [XLEN-1:0]  result_w,
  output logic [CNT_W-1:0] retire_count
);
  localparam int IDX_W  = $clog2(NREGS);
  localparam int NPORTS = 2;

  logic [NREGS-1:0][XLEN-1:0] regs_q;
  logic [CNT_W-1:0]           retire_q, retire_d;
  logic                       we;
  logic [IDX_W-1:0]           wa;

  always_comb begin
    unique case (result_src_w)
      2'b00:   result_w = alu_result_w;
      2'b01:   result_w = read_data_w;
      2'b10:   result_w = pc_plus4_w;
      default: result_w = imm_ext_w;
    endcase
  end

  assign we       = valid_w & reg_write_w & (rd_w != 5'd0) & (int'(rd_w) < NREGS);
  assign wa       = rd_w[IDX_W-1:0];
  assign retire_d = retire_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q   <= '0;
      retire_q <= '0;
    end else begin
      if (we)      regs_q[wa] <= result_w;
      if (valid_w) retire_q   <= retire_d;
    end
  end

  assign retire_count = retire_q;

  logic [NPORTS-1:0][4:0]      rs;
  logic [NPORTS-1:0][XLEN-1:0] rdata;
  assign rs = {rs2_d, rs1_d};

  for (genvar p = 0; p < NPORTS; p++) begin : g_rd
    writeback_regfile_rdport #(.XLEN(XLEN), .NREGS(NREGS)) u_rd (
      .regs_i   (regs_q),
      .rs_i     (rs[p]),
      .we_i     (we),
      .rd_w_i   (rd_w),
      .result_i (result_w),
      .data_o   (rdata[p])
    );
  end

  assign rd1_d = rdata[0];
  assign rd2_d = rdata[1];
endmodule
